// File: rtl/mult_booth4_pipe.sv
// mult_booth4_pipe: three-stage radix-4 Booth multiplier.
//   S1: Booth recoding and partial-product selection
//   S2: carry-save (full-adder) compression down to two rows
//   S3: Sklansky prefix carry-propagate adder
// The input and output sides both use a valid/ready handshake, and a tag travels with each operation.
// Optional feature: define MULT_BOOTH4_PIPE_STATS_EN to add the saturating ops_done counter.
module mult_booth4_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output logic [TAG_W-1:0]   out_tag
`ifdef MULT_BOOTH4_PIPE_STATS_EN
    ,
    output logic [31:0]        ops_done
`endif
);
    localparam int EW  = WIDTH + 2;
    localparam int NPP = EW / 2;
    localparam int PW  = 2 * WIDTH;
    localparam int LVL = $clog2(PW);

    if ((WIDTH % 2) != 0 || WIDTH < 4 || WIDTH > 32 || TAG_W < 1) begin : g_param_check
        $error("mult_booth4_pipe: WIDTH must be even in 4..32 and TAG_W >= 1");
    end

    // Each row is stored as {~sign, low bits}. That biases the row by +2^(EW-1+2i),
    // so the sum of all those biases is subtracted here, once, as a single constant.
    function automatic logic [PW-1:0] sign_const();
        logic [PW-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < NPP; i++) begin
            if (EW - 1 + 2 * i < PW) k = k - (PW'(1) << (EW - 1 + 2 * i));
        end
        return k;
    endfunction
    localparam logic [PW-1:0] SIGN_K = sign_const();

    logic                v1, v2, v3;
    logic                ld1, ld2, ld3;
    logic [EW-1:0]       a_ext, b_ext, mag;
    logic [EW:0]         b_win;
    logic [2:0]          booth_t;
    logic [EW-1:0]       pp_c [NPP];
    logic [NPP-1:0]      neg_c;
    logic [EW-1:0]       s1_pp [NPP];
    logic [NPP-1:0]      s1_neg;
    logic [TAG_W-1:0]    s1_tag, s2_tag, s3_tag;
    logic [PW+EW-1:0]    row_w;
    logic [PW-1:0]       row, maj, cs_s, cs_c;
    logic [PW-1:0]       s2_sum, s2_carry;
    logic [LVL:0][PW-1:0] pg_g, pg_p;
    int unsigned         pj;
    logic [PW-1:0]       cpa_sum, s3_prod;

    // Handshake: a stage loads when it is empty or its occupant moves on; flush blocks input
    always_comb begin
        ld3      = v2 && (!v3 || out_ready);
        ld2      = v1 && (!v2 || ld3);
        in_ready = !flush && (!v1 || ld2);
        ld1      = in_valid && in_ready;
    end

    // Operand extension and Booth select (neg / 1x / 2x) for every multiplier digit
    always_comb begin
        a_ext   = in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
        b_ext   = in_signed ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};
        b_win   = {b_ext, 1'b0};
        booth_t = '0;
        mag     = '0;
        neg_c   = '0;
        for (int unsigned i = 0; i < NPP; i++) begin
            booth_t  = b_win[2*i +: 3];
            neg_c[i] = booth_t[2] & ~(booth_t[1] & booth_t[0]);
            if (booth_t[1] ^ booth_t[0])
                mag = a_ext;
            else if (booth_t == 3'b011 || booth_t == 3'b100)
                mag = a_ext << 1;
            else
                mag = '0;
            pp_c[i] = neg_c[i] ? ~mag : mag;
        end
    end

    // Pipeline occupancy; flush clears every stage and takes priority over any transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (flush) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            v1 <= ld1 || (v1 && !ld2);
            v2 <= ld2 || (v2 && !ld3);
            v3 <= ld3 || (v3 && !out_ready);
        end
    end

    // Stage 1 payload: selected partial products, negation corrections, tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_pp  <= '{default: '0};
            s1_neg <= '0;
            s1_tag <= '0;
        end else if (ld1) begin
            s1_pp  <= pp_c;
            s1_neg <= neg_c;
            s1_tag <= in_tag;
        end
    end

    // Carry-save compression of the shifted rows, correction bits and sign constant
    always_comb begin
        cs_s  = SIGN_K;
        cs_c  = '0;
        row_w = '0;
        row   = '0;
        maj   = '0;
        for (int unsigned i = 0; i < NPP; i++) cs_c[2*i] = s1_neg[i];
        for (int unsigned i = 0; i < NPP; i++) begin
            row_w = '0;
            row_w[2*i +: EW] = {~s1_pp[i][EW-1], s1_pp[i][EW-2:0]};
            row  = row_w[PW-1:0];
            maj  = (cs_s & cs_c) | (cs_s & row) | (cs_c & row);
            cs_s = cs_s ^ cs_c ^ row;
            cs_c = maj << 1;
        end
    end

    // Stage 2 payload: the two compressed rows and tag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sum   <= '0;
            s2_carry <= '0;
            s2_tag   <= '0;
        end else if (ld2) begin
            s2_sum   <= cs_s;
            s2_carry <= cs_c;
            s2_tag   <= s1_tag;
        end
    end

    // Sklansky prefix tree: in each level, the upper half of every block takes the lower half's last group
    always_comb begin
        pj      = 0;
        pg_g[0] = s2_sum & s2_carry;
        pg_p[0] = s2_sum ^ s2_carry;
        for (int unsigned l = 0; l < LVL; l++) begin
            pg_g[l+1] = pg_g[l];
            pg_p[l+1] = pg_p[l];
            for (int unsigned b = 0; b < PW; b++) begin
                if (((b >> l) & 1) != 0) begin
                    pj = ((b >> l) << l) - 1;
                    pg_g[l+1][b] = pg_g[l][b] | (pg_p[l][b] & pg_g[l][pj]);
                    pg_p[l+1][b] = pg_p[l][b] & pg_p[l][pj];
                end
            end
        end
        cpa_sum = pg_p[0] ^ {pg_g[LVL][PW-2:0], 1'b0};
    end

    // Stage 3 payload: final product and tag; held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_prod <= '0;
            s3_tag  <= '0;
        end else if (ld3) begin
            s3_prod <= cpa_sum;
            s3_tag  <= s2_tag;
        end
    end

    assign out_valid   = v3;
    assign out_product = s3_prod;
    assign out_tag     = s3_tag;

`ifdef MULT_BOOTH4_PIPE_STATS_EN
    // Saturating count of completed output transfers; flushed results are not counted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ops_done <= '0;
        else if (!flush && v3 && out_ready && ops_done != '1)
            ops_done <= ops_done + 32'd1;
    end
`endif

endmodule

// File: tb/tb_mult_booth4_pipe.sv
// tb_mult_booth4_pipe: the same stimulus drives four mult_booth4_pipe instances (WIDTH 4/8/16/32).
// A reference model tracks each operation's pipeline position and its exact product.
// If MULT_BOOTH4_PIPE_STATS_EN is defined, the ops_done counter is also checked.
module tb_mult_booth4_pipe;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_signed, out_ready;
    logic [3:0]  in_tag;
    logic [31:0] opa, opb;
    logic        rdy4, rdy8, rdy16, rdy32;
    logic        ov4, ov8, ov16, ov32;
    logic [7:0]  prod4;
    logic [15:0] prod8;
    logic [31:0] prod16;
    logic [63:0] prod32;
    logic [3:0]  tag4, tag8, tag16, tag32;
`ifdef MULT_BOOTH4_PIPE_STATS_EN
    logic [31:0] ops4, ops8, ops16, ops32;
`endif

    typedef struct {
        logic [63:0] p4, p8, p16, p32;
        logic [3:0]  tag;
        int          stage;
    } ent_t;

    ent_t q[$];
    int   seen_tags[$];
    int   nchk = 0, npass = 0, nfail = 0;
    int   naccept = 0, xfers = 0;

    always #5 clk = ~clk;

    mult_booth4_pipe #(.WIDTH(4), .TAG_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy4),
        .in_signed(in_signed), .in_a(opa[3:0]), .in_b(opb[3:0]), .in_tag(in_tag),
        .out_valid(ov4), .out_ready(out_ready), .out_product(prod4), .out_tag(tag4)
`ifdef MULT_BOOTH4_PIPE_STATS_EN
        , .ops_done(ops4)
`endif
    );
    mult_booth4_pipe #(.WIDTH(8), .TAG_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy8),
        .in_signed(in_signed), .in_a(opa[7:0]), .in_b(opb[7:0]), .in_tag(in_tag),
        .out_valid(ov8), .out_ready(out_ready), .out_product(prod8), .out_tag(tag8)
`ifdef MULT_BOOTH4_PIPE_STATS_EN
        , .ops_done(ops8)
`endif
    );
    mult_booth4_pipe #(.WIDTH(16), .TAG_W(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy16),
        .in_signed(in_signed), .in_a(opa[15:0]), .in_b(opb[15:0]), .in_tag(in_tag),
        .out_valid(ov16), .out_ready(out_ready), .out_product(prod16), .out_tag(tag16)
`ifdef MULT_BOOTH4_PIPE_STATS_EN
        , .ops_done(ops16)
`endif
    );
    mult_booth4_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
        .in_signed(in_signed), .in_a(opa), .in_b(opb), .in_tag(in_tag),
        .out_valid(ov32), .out_ready(out_ready), .out_product(prod32), .out_tag(tag32)
`ifdef MULT_BOOTH4_PIPE_STATS_EN
        , .ops_done(ops32)
`endif
    );

    // Exact product of the low w bits of a and b, in the selected mode, truncated to 2w bits
    function automatic logic [63:0] ref_mul(input int w, input logic sgn,
                                            input logic [31:0] a, input logic [31:0] b);
        logic [63:0] msk, ax, bx, r;
        msk = (64'd1 << w) - 64'd1;
        ax  = {32'd0, a} & msk;
        bx  = {32'd0, b} & msk;
        if (sgn && a[w-1]) ax = ax | ~msk;
        if (sgn && b[w-1]) bx = bx | ~msk;
        r = ax * bx;
        if (w < 32) r = r & ((64'd1 << (2 * w)) - 64'd1);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %0h, required %0h", name, obs, exp);
        end
    endtask

    // Called at a falling edge with inputs already driven: check, update the model, run one rising edge
    task automatic tick();
        logic exp_ov, model_rdy, drain;
        int   limit;
        ent_t e;
        #1;
        exp_ov    = (q.size() > 0) && (q[0].stage == 3);
        model_rdy = 1'b0;
        check("out_valid", 64'({ov4, ov8, ov16, ov32}), 64'({4{exp_ov}}));
        if (exp_ov) begin
            check("prod_w4", 64'(prod4), q[0].p4);
            check("prod_w8", 64'(prod8), q[0].p8);
            check("prod_w16", 64'(prod16), q[0].p16);
            check("prod_w32", prod32, q[0].p32);
            check("tag_all", 64'({tag4, tag8, tag16, tag32}), 64'({4{q[0].tag}}));
        end
        if (flush) begin
            q.delete();
        end else begin
            drain = exp_ov && out_ready;
            if (drain) begin
                seen_tags.push_back(int'(tag8));
                void'(q.pop_front());
                xfers++;
            end
            limit     = 4;
            model_rdy = 1'b1;
            for (int i = 0; i < q.size(); i++) begin
                e = q[i];
                if (e.stage < 3 && e.stage + 1 < limit) e.stage++;
                limit = e.stage;
                if (e.stage == 1) model_rdy = 1'b0;
                q[i] = e;
            end
        end
        check("in_ready", 64'({rdy4, rdy8, rdy16, rdy32}), 64'({4{model_rdy}}));
        if (in_valid && model_rdy) begin
            e.p4    = ref_mul(4, in_signed, opa, opb);
            e.p8    = ref_mul(8, in_signed, opa, opb);
            e.p16   = ref_mul(16, in_signed, opa, opb);
            e.p32   = ref_mul(32, in_signed, opa, opb);
            e.tag   = in_tag;
            e.stage = 1;
            q.push_back(e);
            naccept++;
        end
        @(negedge clk);
    endtask

    // Count the rising edges from the accept edge (counted as 1) to out_valid, with a bound
    task automatic wait_result(output int lat);
        lat = 1;
        while (!ov8 && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    task automatic drain_all();
        for (int i = 0; i < 40 && q.size() > 0; i++) tick();
        check("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, acc0, prev, tagn;
        logic [31:0] fa, fb;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
        out_ready = 1'b1; opa = '0; opb = '0; in_tag = '0;
        #3;
        check("rst_out_valid", 64'(ov8), 64'd0);
        check("rst_product", 64'(prod8), 64'd0);
        check("rst_tag", 64'(tag8), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        // signed most-negative squared, latency and tag echo
        in_valid = 1'b1; in_signed = 1'b1; opa = 32'h80; opb = 32'h80; in_tag = 4'd5;
        acc0 = naccept;
        tick();
        in_valid = 1'b0;
        check("t1_accepted", 64'(naccept - acc0), 64'd1);
        wait_result(lat);
        check("t1_latency", 64'(lat), 64'd3);
        check("t1_product", 64'(prod8), 64'h4000);
        check("t1_tag", 64'(tag8), 64'd5);
        tick();

        // unsigned all-ones squared, then signed back-to-back
        in_valid = 1'b1; in_signed = 1'b0; opa = 32'hFF; opb = 32'hFF; in_tag = 4'd1;
        tick();
        in_signed = 1'b1; opa = 32'hFF; opb = 32'h7F; in_tag = 4'd2;
        tick();
        in_valid = 1'b0;
        wait_result(lat);
        check("t2_unsigned_ff", 64'(prod8), 64'hFE01);
        tick();
        check("t2_next_valid", 64'(ov8), 64'd1);
        check("t2_signed_ff_7f", 64'(prod8), 64'hFF81);
        drain_all();

        // mixed-mode stream at one op per cycle, with 32-bit boundary operands first
        acc0 = naccept;
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_signed = (i == 0) ? 1'b1 : (i == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            opa = (i == 0) ? 32'h8000_0000 : (i == 1) ? 32'hFFFF_FFFF : $urandom;
            opb = (i == 0) ? 32'h8000_0000 : (i == 1) ? 32'hFFFF_FFFF : $urandom;
            in_tag = 4'(i);
            tick();
        end
        in_valid = 1'b0;
        check("stream_rate", 64'(naccept - acc0), 64'd8);
        drain_all();

        // backpressure: five ops, consumer stalled for six cycles
        out_ready = 1'b0; in_valid = 1'b1; in_signed = 1'b1;
        tagn = 1; in_tag = 4'd1; opa = $urandom; opb = $urandom;
        fa = opa; fb = opb;
        seen_tags.delete();
        acc0 = naccept;
        for (int c = 0; c < 6; c++) begin
            prev = naccept;
            tick();
            if (naccept != prev) begin
                tagn++; in_tag = 4'(tagn); opa = $urandom; opb = $urandom;
            end
            if (c == 3 || c == 5) begin
                check("stall_product", 64'(prod8), ref_mul(8, 1'b1, fa, fb));
                check("stall_tag", 64'(tag8), 64'd1);
            end
        end
        check("stall_accepts", 64'(naccept - acc0), 64'd3);
        check("stall_in_ready", 64'(rdy8), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 40 && (tagn <= 5 || q.size() > 0); c++) begin
            if (tagn > 5) in_valid = 1'b0;
            prev = naccept;
            tick();
            if (naccept != prev) begin
                tagn++; in_tag = 4'(tagn); opa = $urandom; opb = $urandom;
            end
        end
        in_valid = 1'b0;
        check("order_count", 64'(seen_tags.size()), 64'd5);
        for (int i = 0; i < seen_tags.size(); i++)
            check("order_tag", 64'(seen_tags[i]), 64'(i + 1));

        // flush with two ops in flight and a new request pending
        in_valid = 1'b1; in_signed = 1'b0;
        for (int i = 0; i < 2; i++) begin
            opa = $urandom; opb = $urandom; in_tag = 4'(10 + i);
            tick();
        end
        flush = 1'b1; in_tag = 4'd12;
        #1;
        check("flush_in_ready", 64'(rdy8), 64'd0);
        acc0 = naccept;
        tick();
        check("flush_no_accept", 64'(naccept - acc0), 64'd0);
        flush = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("flush_no_output", 64'(ov8), 64'd0);
            tick();
        end
        in_valid = 1'b1; in_signed = 1'b1; opa = 32'h0000_00C3; opb = 32'h0000_0035; in_tag = 4'd9;
        tick();
        in_valid = 1'b0;
        wait_result(lat);
        check("post_flush_latency", 64'(lat), 64'd3);
        check("post_flush_product", 64'(prod8), ref_mul(8, 1'b1, 32'hC3, 32'h35));
        check("post_flush_tag", 64'(tag8), 64'd9);
        tick();

        // asynchronous reset between clock edges while results are pending
        in_valid = 1'b1; in_signed = 1'b0; opa = 32'h12; opb = 32'h34;
        for (int i = 0; i < 4; i++) begin
            in_tag = 4'(3 + i);
            tick();
        end
        in_valid = 1'b0;
        check("pre_reset_valid", 64'(ov8), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(ov8), 64'd0);
        check("async_rst_product", 64'(prod8), 64'd0);
        check("async_rst_tag", 64'(tag8), 64'd0);
        q.delete();
        xfers = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(rdy8), 64'd1);
        in_valid = 1'b1; in_signed = 1'b1; opa = 32'hFFFF_FF85; opb = 32'h0000_0067; in_tag = 4'd7;
        tick();
        in_valid = 1'b0;
        wait_result(lat);
        check("post_rst_latency", 64'(lat), 64'd3);
        check("post_rst_product", 64'(prod8), ref_mul(8, 1'b1, 32'hFFFF_FF85, 32'h67));
        tick();

        // random regression with random valid, ready, mode and occasional flush
        for (int i = 0; i < 600; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_signed = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
            opa = $urandom; opb = $urandom; in_tag = 4'($urandom);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drain_all();

`ifdef MULT_BOOTH4_PIPE_STATS_EN
        check("ops_done_w8", 64'(ops8), 64'(xfers));
        check("ops_done_all", {ops4, ops32}, {ops16, ops8});
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
